soc_system_acc_sequencer: RTL and testbench
===========================================

// Module: soc_system_acc_sequencer
// PURPOSE
// - Avalon-MM slave that sequences the 8-bit accelerator control port: HPS writes opcode+GO, block pulses CLR/START, waits for DONE, records cycles/status.
// - Sits between lightweight HPS bridge and accelerator; replaces software bit-banging of the control PIO.
// PARAMETERS
// - TMO_W      16   width of timeout limit and cycle counter
// - TMO_RST    1000 reset value of timeout limit (0 = no timeout)
// PORTS
// - clk         in   1      system clock
// - reset_n     in   1      synchronous active-low reset, sampled on posedge clk
// - address     in   2      register select
// - chipselect  in   1      slave select
// - write_n     in   1      active-low write strobe
// - writedata   in   32     write data
// - readdata    out  32     registered read data
// - acc_ctrl    out  8      {opcode[3:0], 2'b00, clr, start} to accelerator
// - acc_status  in   8      bit0 done, bit1 err, rest ignored; same clock domain
// BEHAVIOUR
// - Write = chipselect & ~write_n; reads side-effect free; readdata updated every cycle from address (1-cycle latency), unused bits 0.
// - Reg 0 CTRL: wr bit0 GO, bits[7:4] opcode; rd {24'b0, opcode, 3'b0, busy}.
// - Reg 1 STATUS: rd {26'b0, state[1:0], overrun, err, timeout, done}; wr 1 to bits[3:0] clears matching sticky flag (W1C).
// - Reg 2 TMO: rd/wr limit[TMO_W-1:0]; write while busy ignored.
// - Reg 3 CYCLES: rd cycles of last op, read-only, saturates at all-ones.
// - FSM (state enc): IDLE=0, CLR=1, START=2, WAIT=3.
// - IDLE: GO write -> latch opcode, clear done/timeout/err, zero counter, -> CLR.
// - CLR: acc_ctrl[1]=1 one cycle -> START. START: acc_ctrl[0]=1 one cycle -> WAIT.
// - opcode driven on acc_ctrl[7:4] from CLR through WAIT; 0 in IDLE.
// - WAIT: counter++ per cycle (saturating). done=1 -> set done, err<=acc_status[1], -> IDLE.
// - WAIT: counter==limit and limit!=0 and done=0 -> set timeout, acc_ctrl=0, -> IDLE.
// - done and timeout same cycle: done wins, timeout not set.
// - CYCLES reg loaded on WAIT exit (done or timeout).
// - busy = (state!=IDLE). GO while busy: ignored, overrun set.
// - GO and W1C same cycle: GO action takes effect; W1C applies only to overrun.
// - Reset (incl. mid-op): state IDLE, acc_ctrl=0, readdata=0, flags=0, opcode=0, CYCLES=0, TMO=TMO_RST.
// CONFIGURATION
// - ACC_SEQ_IRQ_EN defined: adds output irq (1 bit), level, = (done|timeout) & ie;
//   ie is CTRL bit1 (rw, reset 0, written on every CTRL write); irq drops when flags cleared.
// - Undefined: no irq port, CTRL bit1 reads 0 and writes ignored.
// TESTING
// - TMO=100, GO op=5, done at 10th WAIT cycle -> CLR then START 1-cycle pulses, acc_ctrl[7:4]=5, STATUS.done=1, CYCLES=10.
// - TMO=20, no done -> timeout=1 after 20 WAIT cycles, acc_ctrl=0, CYCLES=20, busy=0.
// - done and counter==limit same cycle (TMO=8, done on 8th) -> done=1, timeout=0.
// - GO while in WAIT -> overrun=1, opcode unchanged; write STATUS 0x8 -> overrun=0.
// - reset_n low for 1 cycle mid-WAIT -> next cycle IDLE, acc_ctrl=0, TMO=1000, all readdata regs 0 except TMO.
// - ACC_SEQ_IRQ_EN: CTRL=0x03, done -> irq=1; write STATUS 0x1 -> irq=0.

Source files
------------

// File: rtl/soc_system_acc_sequencer.sv
// Avalon-MM sequencer for the 8-bit accelerator control port: GO -> CLR pulse -> START pulse -> wait for DONE or timeout.
// Optional feature macro: ACC_SEQ_IRQ_EN adds a level irq output gated by CTRL bit1.
module soc_system_acc_sequencer #(
    parameter int TMO_W   = 16,
    parameter int TMO_RST = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  acc_ctrl,
    input  logic [7:0]  acc_status
`ifdef ACC_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [3:0]       opcode;
    logic [TMO_W-1:0] tmo_limit;
    logic [TMO_W-1:0] cycle_cnt;
    logic [TMO_W-1:0] cycle_inc;
    logic [TMO_W-1:0] cycles_last;
    logic             done_flag;
    logic             timeout_flag;
    logic             err_flag;
    logic             overrun_flag;
    logic             ie_bit;

    logic wr_en;
    logic wr_ctrl;
    logic wr_status;
    logic wr_tmo;
    logic go_req;
    logic go_accept;
    logic go_overrun;
    logic busy;
    logic acc_done;
    logic wait_done;
    logic wait_tmo;
    logic unused_ok;

    assign wr_en      = chipselect & ~write_n;
    assign wr_ctrl    = wr_en && (address == 2'd0);
    assign wr_status  = wr_en && (address == 2'd1);
    assign busy       = (state != ST_IDLE);
    assign wr_tmo     = wr_en && (address == 2'd2) && !busy;
    assign go_req     = wr_ctrl & writedata[0];
    assign go_accept  = go_req & ~busy;
    assign go_overrun = go_req & busy;

    assign acc_done  = acc_status[0];
    assign cycle_inc = (cycle_cnt == {TMO_W{1'b1}}) ? cycle_cnt : cycle_cnt + TMO_W'(1);

    // The comparison uses the post-increment count so the limit equals the number of WAIT cycles spent.
    assign wait_done = (state == ST_WAIT) && acc_done;
    assign wait_tmo  = (state == ST_WAIT) && !acc_done && (tmo_limit != '0) && (cycle_inc == tmo_limit);

    assign unused_ok = ^{acc_status[7:2], writedata};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (go_accept) begin
                    state_next = ST_CLR;
                end
            end
            ST_CLR: begin
                state_next = ST_START;
            end
            ST_START: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_done || wait_tmo) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        acc_ctrl = 8'h00;
        case (state)
            ST_CLR:   acc_ctrl = {opcode, 2'b00, 1'b1, 1'b0};
            ST_START: acc_ctrl = {opcode, 2'b00, 1'b0, 1'b1};
            ST_WAIT:  acc_ctrl = {opcode, 2'b00, 1'b0, 1'b0};
            default:  acc_ctrl = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opcode      <= 4'h0;
            cycle_cnt   <= '0;
            cycles_last <= '0;
            tmo_limit   <= TMO_W'(TMO_RST);
        end else begin
            if (go_accept) begin
                opcode    <= writedata[7:4];
                cycle_cnt <= '0;
            end else if (state == ST_WAIT) begin
                cycle_cnt <= cycle_inc;
            end
            if (wait_done || wait_tmo) begin
                cycles_last <= cycle_inc;
            end
            if (wr_tmo) begin
                tmo_limit <= writedata[TMO_W-1:0];
            end
        end
    end

    // Hardware events take priority over a software W1C landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_flag    <= 1'b0;
            timeout_flag <= 1'b0;
            err_flag     <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            if (go_accept) begin
                done_flag <= 1'b0;
            end else if (wait_done) begin
                done_flag <= 1'b1;
            end else if (wr_status && writedata[0]) begin
                done_flag <= 1'b0;
            end

            if (go_accept) begin
                timeout_flag <= 1'b0;
            end else if (wait_tmo) begin
                timeout_flag <= 1'b1;
            end else if (wr_status && writedata[1]) begin
                timeout_flag <= 1'b0;
            end

            if (go_accept) begin
                err_flag <= 1'b0;
            end else if (wait_done) begin
                err_flag <= acc_status[1];
            end else if (wr_status && writedata[2]) begin
                err_flag <= 1'b0;
            end

            if (go_overrun) begin
                overrun_flag <= 1'b1;
            end else if (wr_status && writedata[3]) begin
                overrun_flag <= 1'b0;
            end
        end
    end

`ifdef ACC_SEQ_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            irq_en <= writedata[1];
        end
    end

    assign ie_bit = irq_en;
    assign irq    = (done_flag | timeout_flag) & irq_en;
`else
    assign ie_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= 32'h0;
        end else begin
            case (address)
                2'd0:    readdata <= {24'h0, opcode, 2'b00, ie_bit, busy};
                2'd1:    readdata <= {26'h0, state, overrun_flag, err_flag, timeout_flag, done_flag};
                2'd2:    readdata <= 32'(tmo_limit);
                default: readdata <= 32'(cycles_last);
            endcase
        end
    end

endmodule

// File: tb/tb_soc_system_acc_sequencer.sv
// Self-checking bench for soc_system_acc_sequencer: directed vector table, hand-written corner sequences
// and randomized operations scored against an outcome model.
module tb_soc_system_acc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic [7:0]  acc_ctrl;
    logic [7:0]  acc_status = 8'h00;
`ifdef ACC_SEQ_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] limit;
        logic [3:0]  op;
        int          done_at;
        logic        err_in;
        logic [3:0]  exp_flags;
        int          exp_cycles;
    } op_vec_t;

    soc_system_acc_sequencer #(.TMO_W(16), .TMO_RST(1000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .acc_ctrl   (acc_ctrl),
        .acc_status (acc_status)
`ifdef ACC_SEQ_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        data       = readdata;
        chipselect = 1'b0;
    endtask

    // Outcome of one operation from the rules: done wins if it arrives no later than the limit.
    function automatic op_vec_t modelOp(input logic [15:0] limit, input logic [3:0] op,
                                        input int done_at, input logic err_in);
        op_vec_t v;
        v.limit   = limit;
        v.op      = op;
        v.done_at = done_at;
        v.err_in  = err_in;
        if (done_at != 0 && (limit == 16'd0 || done_at <= int'(limit))) begin
            v.exp_flags  = {1'b0, err_in, 1'b0, 1'b1};
            v.exp_cycles = done_at;
        end else begin
            v.exp_flags  = 4'b0010;
            v.exp_cycles = int'(limit);
        end
        return v;
    endfunction

    task automatic applyStimulus(input op_vec_t v, input string tag);
        logic [31:0] rd;
        busWrite(2'd2, 32'(v.limit));
        busWrite(2'd0, {24'h0, v.op, 4'b0001});
        checkOutput({tag, " clr pulse"}, 32'(acc_ctrl), 32'({v.op, 4'b0010}));
        tick();
        checkOutput({tag, " start pulse"}, 32'(acc_ctrl), 32'({v.op, 4'b0001}));
        for (int k = 1; k <= v.exp_cycles; k++) begin
            tick();
            checkOutput({tag, " wait ctrl"}, 32'(acc_ctrl), 32'({v.op, 4'b0000}));
            acc_status = {6'b0, v.err_in, (k == v.done_at)};
        end
        tick();
        acc_status = 8'h00;
        checkOutput({tag, " idle ctrl"}, 32'(acc_ctrl), 32'h0);
        busRead(2'd1, rd);
        checkOutput({tag, " status"}, rd, 32'(v.exp_flags));
        busRead(2'd3, rd);
        checkOutput({tag, " cycles"}, rd, 32'(v.exp_cycles));
        busRead(2'd0, rd);
        checkOutput({tag, " ctrl rd"}, rd, 32'({v.op, 4'b0000}));
        busRead(2'd2, rd);
        checkOutput({tag, " tmo rd"}, rd, 32'(v.limit));
    endtask

    initial begin
        op_vec_t     vecs[8];
        op_vec_t     rv;
        logic [31:0] rd;
        logic [15:0] lim;
        int          dat;

        vecs[0] = '{16'd100, 4'd5,  10, 1'b0, 4'b0001, 10};
        vecs[1] = '{16'd20,  4'd3,  0,  1'b1, 4'b0010, 20};
        vecs[2] = '{16'd8,   4'd7,  8,  1'b0, 4'b0001, 8};
        vecs[3] = '{16'd8,   4'd9,  9,  1'b0, 4'b0010, 8};
        vecs[4] = '{16'd0,   4'd2,  37, 1'b1, 4'b0101, 37};
        vecs[5] = '{16'd1,   4'd4,  1,  1'b1, 4'b0101, 1};
        vecs[6] = '{16'd1,   4'd15, 0,  1'b0, 4'b0010, 1};
        vecs[7] = '{16'd5,   4'd1,  4,  1'b1, 4'b0101, 4};

        $display("[TB] reset values");
        tick();
        tick();
        checkOutput("reset readdata", readdata, 32'h0);
        reset_n = 1'b1;
        checkOutput("reset acc_ctrl", 32'(acc_ctrl), 32'h0);
        busRead(2'd0, rd);
        checkOutput("reset ctrl", rd, 32'h0);
        busRead(2'd1, rd);
        checkOutput("reset status", rd, 32'h0);
        busRead(2'd2, rd);
        checkOutput("reset tmo", rd, 32'd1000);
        busRead(2'd3, rd);
        checkOutput("reset cycles", rd, 32'h0);

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        $display("[TB] overrun sequence");
        busWrite(2'd2, 32'd50);
        busWrite(2'd0, 32'h51);
        tick();
        tick();
        tick();
        busWrite(2'd0, 32'hA1);
        checkOutput("overrun opcode kept", 32'(acc_ctrl), 32'h50);
        busWrite(2'd2, 32'd7);
        busRead(2'd1, rd);
        checkOutput("overrun status busy", rd, 32'h38);
        busRead(2'd0, rd);
        checkOutput("overrun ctrl busy", rd, 32'h51);
        busRead(2'd2, rd);
        checkOutput("tmo write while busy", rd, 32'd50);
        acc_status = 8'h01;
        tick();
        acc_status = 8'h00;
        busRead(2'd1, rd);
        checkOutput("overrun after done", rd, 32'h09);
        busWrite(2'd1, 32'h8);
        busRead(2'd1, rd);
        checkOutput("w1c overrun", rd, 32'h01);
        busWrite(2'd1, 32'h1);
        busRead(2'd1, rd);
        checkOutput("w1c done", rd, 32'h00);

        $display("[TB] randomized operations");
        for (int i = 0; i < 20; i++) begin
            lim = 16'($urandom_range(0, 40));
            if (lim == 16'd0) begin
                dat = int'($urandom_range(1, 40));
            end else begin
                dat = int'($urandom_range(0, 45));
            end
            rv = modelOp(lim, 4'($urandom_range(1, 15)), dat, 1'($urandom));
            applyStimulus(rv, $sformatf("rnd%0d", i));
        end

        $display("[TB] reset mid-wait");
        busWrite(2'd2, 32'd200);
        busWrite(2'd0, 32'h31);
        tick();
        tick();
        tick();
        busWrite(2'd0, 32'h01);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("midreset acc_ctrl", 32'(acc_ctrl), 32'h0);
        checkOutput("midreset readdata", readdata, 32'h0);
        busRead(2'd0, rd);
        checkOutput("midreset ctrl", rd, 32'h0);
        busRead(2'd1, rd);
        checkOutput("midreset status", rd, 32'h0);
        busRead(2'd2, rd);
        checkOutput("midreset tmo", rd, 32'd1000);
        busRead(2'd3, rd);
        checkOutput("midreset cycles", rd, 32'h0);
        tick();
        checkOutput("midreset stays idle", 32'(acc_ctrl), 32'h0);

`ifdef ACC_SEQ_IRQ_EN
        $display("[TB] irq sequence");
        busWrite(2'd2, 32'd100);
        busWrite(2'd0, 32'h03);
        checkOutput("irq low while busy", 32'(irq), 32'h0);
        tick();
        tick();
        acc_status = 8'h01;
        tick();
        acc_status = 8'h00;
        checkOutput("irq on done", 32'(irq), 32'h1);
        busRead(2'd0, rd);
        checkOutput("irq ctrl ie", rd, 32'h02);
        busWrite(2'd1, 32'h1);
        checkOutput("irq cleared", 32'(irq), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
